// File: rtl/alu_issue_ctrl.sv
// Issue controller wrapping a combinational ALU: IDLE -> EXEC -> RESP.
// Optional ALU_ISSUE_OPCNT_EN adds a 16-bit completed-response counter.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_funct,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    input  logic [4:0]  req_shamt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_error,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_c,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [4:0]  alu_shamt,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_carry
`ifdef ALU_ISSUE_OPCNT_EN
    ,
    output logic [15:0] op_count
`endif
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    logic [1:0] state;
    logic       funct_legal;
    logic       accept;

    assign funct_legal = !req_funct[4] && (req_funct[3:0] <= 4'hA);
    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign accept      = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_shamt  <= '0;
            alu_ctrl   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (funct_legal) begin
                            alu_in1   <= req_rs;
                            alu_in2   <= req_rt;
                            alu_shamt <= req_shamt;
                            alu_ctrl  <= req_funct[3:0];
                            state     <= EXEC;
                        end else begin
                            // ALU drive stays put so the last legal op is not disturbed
                            rsp_result <= '0;
                            rsp_error  <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                EXEC: begin
                    rsp_result <= alu_out;
                    rsp_error  <= 1'b0;
                    flag_n     <= alu_negative;
                    flag_z     <= alu_zero;
                    flag_c     <= alu_carry;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_OPCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU.
// Define ALU_ISSUE_OPCNT_EN to also check op_count.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_funct;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic [4:0]  req_shamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_negative;
    logic        alu_zero;
    logic        alu_carry;
`ifdef ALU_ISSUE_OPCNT_EN
    logic [15:0] op_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct    (req_funct),
        .req_rs       (req_rs),
        .req_rt       (req_rt),
        .req_shamt    (req_shamt),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_error    (rsp_error),
        .flag_n       (flag_n),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_shamt    (alu_shamt),
        .alu_ctrl     (alu_ctrl),
        .alu_out      (alu_out),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry)
`ifdef ALU_ISSUE_OPCNT_EN
        ,
        .op_count     (op_count)
`endif
    );

    // Reference ALU: shifts act on operand A, variable shifts use B[4:0]
    logic [32:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        case (alu_ctrl)
            4'h0: alu_wide = {1'b0, alu_in1} + {1'b0, alu_in2};
            4'h1: alu_wide = {1'b0, ~alu_in2};
            4'h2: alu_wide = {1'b0, alu_in1} - {1'b0, alu_in2};
            4'h3: alu_wide = {1'b0, alu_in1 & alu_in2};
            4'h4: alu_wide = {1'b0, alu_in1 ^ alu_in2};
            4'h5: alu_wide = {1'b0, alu_in1 << alu_shamt};
            4'h6: alu_wide = {1'b0, alu_in1 >> alu_shamt};
            4'h7: alu_wide = {1'b0, $signed(alu_in1) >>> alu_shamt};
            4'h8: alu_wide = {1'b0, alu_in1 >> alu_in2[4:0]};
            4'h9: alu_wide = {1'b0, alu_in1 << alu_in2[4:0]};
            4'hA: alu_wide = {1'b0, $signed(alu_in1) >>> alu_in2[4:0]};
            default: alu_wide = '0;
        endcase
    end
    assign alu_out      = alu_wide[31:0];
    assign alu_carry    = alu_wide[32];
    assign alu_negative = alu_wide[31];
    assign alu_zero     = (alu_wide[31:0] == 32'd0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] s);
        req_valid = 1'b1;
        req_funct = f;
        req_rs    = a;
        req_rt    = b;
        req_shamt = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_checks++; if (rsp_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", rsp_result); end
        n_checks++; if (rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", rsp_error); end
        n_checks++; if ({flag_n, flag_z, flag_c} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {flag_n, flag_z, flag_c}); end
        n_checks++; if ({alu_in1, alu_in2, alu_shamt, alu_ctrl} !== 73'd0) begin n_fail++; $display("FAIL reset_alu_drive got %h want 0", {alu_in1, alu_in2, alu_shamt, alu_ctrl}); end
`ifdef ALU_ISSUE_OPCNT_EN
        n_checks++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count got %0d want 0", op_count); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_add();
        send(5'd0, 32'h7FFF_FFFF, 32'd1, 5'd9);
        step();
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid got %b want 0", rsp_valid); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL add_exec_ready got %b want 0", req_ready); end
        n_checks++; if (alu_in1 !== 32'h7FFF_FFFF || alu_in2 !== 32'd1) begin n_fail++; $display("FAIL add_operands got %h %h want 7fffffff 00000001", alu_in1, alu_in2); end
        n_checks++; if (alu_shamt !== 5'd9 || alu_ctrl !== 4'h0) begin n_fail++; $display("FAIL add_ctrl got %0d %h want 9 0", alu_shamt, alu_ctrl); end
        step();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", rsp_valid); end
        n_checks++; if (rsp_result !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result got %h want 80000000", rsp_result); end
        n_checks++; if ({flag_n, flag_z, flag_c, rsp_error} !== 4'b1000) begin n_fail++; $display("FAIL add_flags got nzc_err=%b want 1000", {flag_n, flag_z, flag_c, rsp_error}); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL add_release got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
    endtask

    task automatic test_illegal(input logic [4:0] f, input logic [3:0] exp_ctrl,
                                input logic [31:0] exp_in1, input logic [2:0] exp_flags);
        send(f, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17);
        step();
        req_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_valid f=%b got %b want 1", f, rsp_valid); end
        n_checks++; if (rsp_error !== 1'b1 || rsp_result !== 32'd0) begin n_fail++; $display("FAIL illegal_rsp f=%b got err=%b res=%h want 1 0", f, rsp_error, rsp_result); end
        n_checks++; if ({flag_n, flag_z, flag_c} !== exp_flags) begin n_fail++; $display("FAIL illegal_flags f=%b got %b want %b", f, {flag_n, flag_z, flag_c}, exp_flags); end
        n_checks++; if (alu_ctrl !== exp_ctrl || alu_in1 !== exp_in1) begin n_fail++; $display("FAIL illegal_drive f=%b got %h %h want %h %h", f, alu_ctrl, alu_in1, exp_ctrl, exp_in1); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_release f=%b got %b want 1", f, req_ready); end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        send(5'd7, 32'h8000_0000, 32'h0000_0003, 5'd4);
        step();
        send(5'd0, 32'h1111_1111, 32'h2, 5'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hF800_0000) begin n_fail++; $display("FAIL bp_hold%0d got v=%b res=%h want 1 f8000000", i, rsp_valid, rsp_result); end
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d got %b want 0", i, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        send(5'd4, 32'h0000_1234, 32'h1, 5'd2);
        if (rsp_valid && rsp_ready) hs++;
        step();
        if (rsp_valid && rsp_ready) hs++;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        n_checks++; if (hs !== 1) begin n_fail++; $display("FAIL bp_handshakes got %0d want 1", hs); end
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got r=%b v=%b want 1 0", req_ready, rsp_valid); end
        n_checks++; if (alu_in1 !== 32'h8000_0000 || alu_ctrl !== 4'h7) begin n_fail++; $display("FAIL bp_no_bypass got %h %h want 80000000 7", alu_in1, alu_ctrl); end
        n_checks++; if ({flag_n, flag_z} !== 2'b10) begin n_fail++; $display("FAIL bp_flags got %b want 10", {flag_n, flag_z}); end
    endtask

    task automatic test_reset_mid_exec();
        send(5'd2, 32'd10, 32'd3, 5'd0);
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        rsp_ready = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_exec_state got v=%b r=%b want 0 1", rsp_valid, req_ready); end
        n_checks++; if (rsp_result !== 32'd0 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL rst_exec_rsp got %h %b want 0 0", rsp_result, rsp_error); end
        n_checks++; if ({flag_n, flag_z, flag_c} !== 3'b000) begin n_fail++; $display("FAIL rst_exec_flags got %b want 000", {flag_n, flag_z, flag_c}); end
        n_checks++; if ({alu_in1, alu_in2, alu_shamt, alu_ctrl} !== 73'd0) begin n_fail++; $display("FAIL rst_exec_drive got %h want 0", {alu_in1, alu_in2, alu_shamt, alu_ctrl}); end
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_exec_late_valid got %b want 0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  f[4]  = '{5'd0, 5'd2, 5'd4, 5'd5};
        logic [31:0] a[4]  = '{32'd1, 32'd5, 32'hF0, 32'd1};
        logic [31:0] b[4]  = '{32'd2, 32'd5, 32'h0F, 32'd0};
        logic [4:0]  s[4]  = '{5'd0, 5'd0, 5'd0, 5'd3};
        logic [31:0] exp[4] = '{32'd3, 32'd0, 32'hFF, 32'd8};
        logic        ez[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        int issued = 0;
        int got = 0;
        int last = -1;
        int cyc = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        while (got < 4 && cyc < 40) begin
            if (rsp_valid) begin
                n_checks++; if (rsp_result !== exp[got] || flag_z !== ez[got] || rsp_error !== 1'b0) begin n_fail++; $display("FAIL stream_rsp%0d got res=%h z=%b err=%b want %h %b 0", got, rsp_result, flag_z, rsp_error, exp[got], ez[got]); end
                if (last >= 0) begin
                    n_checks++; if (cyc - last !== 3) begin n_fail++; $display("FAIL stream_gap%0d got %0d want 3", got, cyc - last); end
                end
                last = cyc;
                got++;
            end
            if (req_ready && issued < 4) begin
                send(f[issued], a[issued], b[issued], s[issued]);
                issued++;
            end
            step();
            cyc++;
        end
        req_valid = 1'b0;
        n_checks++; if (got !== 4) begin n_fail++; $display("FAIL stream_count got %0d want 4", got); end
`ifdef ALU_ISSUE_OPCNT_EN
        n_checks++; if (op_count !== 16'd4) begin n_fail++; $display("FAIL stream_op_count got %0d want 4", op_count); end
`endif
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_funct = '0;
        req_rs = '0;
        req_rt = '0;
        req_shamt = '0;
        rsp_ready = 1'b0;
        #1;
        test_reset();
        test_add();
        test_illegal(5'b10000, 4'h0, 32'h7FFF_FFFF, 3'b100);
        test_backpressure();
        test_illegal(5'b01011, 4'h7, 32'h8000_0000, 3'b100);
        test_reset_mid_exec();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
